// File: rtl/replica_pkg.sv
// Shared types for the replica-exchange run-time sequencer.
// REPLICA_SEQ_PAUSE_EN adds the HOLD state used by the optional pause input.
package replica_pkg;

    typedef enum logic [1:0] {
        OPT_THRU = 2'd0,
        OPT_OR1  = 2'd1,
        OPT_OR0  = 2'd2,
        OPT_TWO  = 2'd3
    } opt_command_t;

    typedef enum logic [1:0] {
        D_NOP   = 2'd0,
        D_FIRST = 2'd1,
        D_RUN   = 2'd2,
        D_LAST  = 2'd3
    } distance_command_t;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        OPT,
        DIST,
        METRO,
        REPL,
        EXCH,
        FIN
`ifdef REPLICA_SEQ_PAUSE_EN
        , HOLD
`endif
    } seq_state_t;

    // Phase lengths are at most 15 cycles.
    localparam int PHASE_W = 4;

endpackage

// File: rtl/replica_seq_phase.sv
// Loadable phase-length down-counter; tc flags the last cycle of a phase.
module replica_seq_phase
    import replica_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_value,
    output logic [PHASE_W-1:0] count,
    output logic               tc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - PHASE_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/replica_seq.sv
// Run-time sequencer: steps the node array through opt/dist/metro/repl/exch per iteration.
// Define REPLICA_SEQ_PAUSE_EN to add the pause input and HOLD state.
module replica_seq
    import replica_pkg::*;
#(
    parameter int DIST_CYCLES = 4,
    parameter int EXCH_CYCLES = 3,
    parameter int ITER_W      = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ITER_W-1:0]    run_times,
    input  opt_command_t         mode,
    input  logic [16:0]          recip,
`ifdef REPLICA_SEQ_PAUSE_EN
    input  logic                 pause,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 opt_run,
    output opt_command_t         opt_com,
    output opt_command_t         opt_command,
    output distance_command_t    or_distance_com,
    output distance_command_t    tw_distance_com,
    output logic                 or_metropolis_run,
    output logic                 tw_metropolis_run,
    output logic                 or_replica_run,
    output logic                 tw_replica_run,
    output logic                 or_exchange_run,
    output logic                 tw_exchange_run,
    output logic                 exp_init,
    output logic                 exp_run,
    output logic [16:0]          exp_recip,
    output seq_state_t           fsm_state
);

    // Host handshake: start is accepted only in IDLE; busy rises the next cycle and
    // stays high through the done pulse; a start seen while busy is dropped.
    seq_state_t          state, nxt;
    logic [ITER_W-1:0]   cnt;
    logic                parity;
    logic                phase_load;
    logic [PHASE_W-1:0]  phase_value;
    logic [PHASE_W-1:0]  phase_count;
    logic                phase_tc;
    distance_command_t   dist_next;

    assign phase_load  = (state == OPT) || (state == REPL);
    assign phase_value = (state == OPT) ? PHASE_W'(DIST_CYCLES - 1) : PHASE_W'(EXCH_CYCLES - 1);
    assign fsm_state   = state;

    replica_seq_phase u_phase (
        .clk        (clk),
        .reset      (reset),
        .load       (phase_load),
        .load_value (phase_value),
        .count      (phase_count),
        .tc         (phase_tc)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start) nxt = INIT;
            INIT:  nxt = (cnt == '0) ? FIN : OPT;
            OPT:   nxt = DIST;
            DIST:  if (phase_tc) nxt = METRO;
            METRO: nxt = REPL;
            REPL:  nxt = EXCH;
            EXCH: begin
                if (phase_tc) begin
`ifdef REPLICA_SEQ_PAUSE_EN
                    if (pause) nxt = HOLD;
                    else
`endif
                    nxt = (cnt == ITER_W'(1)) ? FIN : OPT;
                end
            end
`ifdef REPLICA_SEQ_PAUSE_EN
            // cnt was already decremented when leaving EXCH.
            HOLD:  if (!pause) nxt = (cnt == '0) ? FIN : OPT;
`endif
            FIN:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        dist_next = D_NOP;
        if (nxt == DIST) begin
            if (state != DIST)                   dist_next = D_FIRST;
            else if (phase_count == PHASE_W'(1)) dist_next = D_LAST;
            else                                 dist_next = D_RUN;
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            parity            <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            opt_run           <= 1'b0;
            opt_com           <= OPT_THRU;
            opt_command       <= OPT_THRU;
            or_distance_com   <= D_NOP;
            tw_distance_com   <= D_NOP;
            or_metropolis_run <= 1'b0;
            tw_metropolis_run <= 1'b0;
            or_replica_run    <= 1'b0;
            tw_replica_run    <= 1'b0;
            or_exchange_run   <= 1'b0;
            tw_exchange_run   <= 1'b0;
            exp_init          <= 1'b0;
            exp_run           <= 1'b0;
            exp_recip         <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                cnt       <= run_times;
                opt_com   <= mode;
                exp_recip <= recip;
            end
            if (state == INIT) parity <= 1'b0;
            if (state == EXCH && phase_tc) begin
                cnt    <= cnt - ITER_W'(1);
                parity <= ~parity;
            end
            busy              <= (nxt != IDLE);
            done              <= (nxt == FIN);
            exp_init          <= (nxt == INIT);
            opt_run           <= (nxt == OPT);
            opt_command       <= (nxt == OPT) ? opt_com : OPT_THRU;
            or_distance_com   <= dist_next;
            tw_distance_com   <= dist_next;
            or_metropolis_run <= (nxt == METRO);
            tw_metropolis_run <= (nxt == METRO);
            exp_run           <= (nxt == METRO);
            or_replica_run    <= (nxt == REPL) && !parity;
            tw_replica_run    <= (nxt == REPL) && parity;
            or_exchange_run   <= (nxt == EXCH);
            tw_exchange_run   <= (nxt == EXCH);
        end
    end

endmodule

// File: tb/tb_replica_seq.sv
// Self-checking bench for replica_seq: per-cycle schedule model plus directed timing pins.
// Define REPLICA_SEQ_PAUSE_EN to also exercise the pause/HOLD path.
module tb_replica_seq;
    import replica_pkg::*;

    localparam int D = 4;
    localparam int E = 3;
    localparam int L = 3 + D + E;
    localparam int W = 20;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        opt_run;
        logic [1:0]  opt_com;
        logic [1:0]  opt_command;
        logic [1:0]  or_dist;
        logic [1:0]  tw_dist;
        logic        or_met;
        logic        tw_met;
        logic        or_rep;
        logic        tw_rep;
        logic        or_ex;
        logic        tw_ex;
        logic        exp_init;
        logic        exp_run;
        logic [16:0] exp_recip;
    } outs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic [W-1:0] run_times = '0;
    opt_command_t mode = OPT_THRU;
    logic [16:0] recip = '0;

    logic busy, done, opt_run, exp_init, exp_run;
    logic or_metropolis_run, tw_metropolis_run, or_replica_run, tw_replica_run;
    logic or_exchange_run, tw_exchange_run;
    opt_command_t opt_com, opt_command;
    distance_command_t or_distance_com, tw_distance_com;
    logic [16:0] exp_recip;
    seq_state_t fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    bit chk_en = 0;
    outs_t exp_o;
    outs_t trace [0:63];
    logic [W-1:0] exp_q[$];

    // Behavioural model: position p within the run, counted from the start cycle.
    bit m_running = 0;
    bit m_holding = 0;
    longint m_p = 0;
    longint m_n = 0;
    opt_command_t m_mode = OPT_THRU;
    logic [16:0] m_recip = '0;

    replica_seq dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .run_times         (run_times),
        .mode              (mode),
        .recip             (recip),
`ifdef REPLICA_SEQ_PAUSE_EN
        .pause             (pause),
`endif
        .busy              (busy),
        .done              (done),
        .opt_run           (opt_run),
        .opt_com           (opt_com),
        .opt_command       (opt_command),
        .or_distance_com   (or_distance_com),
        .tw_distance_com   (tw_distance_com),
        .or_metropolis_run (or_metropolis_run),
        .tw_metropolis_run (tw_metropolis_run),
        .or_replica_run    (or_replica_run),
        .tw_replica_run    (tw_replica_run),
        .or_exchange_run   (or_exchange_run),
        .tw_exchange_run   (tw_exchange_run),
        .exp_init          (exp_init),
        .exp_run           (exp_run),
        .exp_recip         (exp_recip),
        .fsm_state         (fsm_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic outs_t pack_dut();
        outs_t o;
        o.busy = busy;             o.done = done;               o.opt_run = opt_run;
        o.opt_com = opt_com;       o.opt_command = opt_command;
        o.or_dist = or_distance_com; o.tw_dist = tw_distance_com;
        o.or_met = or_metropolis_run; o.tw_met = tw_metropolis_run;
        o.or_rep = or_replica_run; o.tw_rep = tw_replica_run;
        o.or_ex = or_exchange_run; o.tw_ex = tw_exchange_run;
        o.exp_init = exp_init;     o.exp_run = exp_run;         o.exp_recip = exp_recip;
        return o;
    endfunction

    function automatic outs_t model_out();
        outs_t o;
        longint off, it;
        o = '0;
        o.opt_com = m_mode;
        o.exp_recip = m_recip;
        if (m_running) begin
            o.busy = 1'b1;
            if (!m_holding) begin
                if (m_p == 1) o.exp_init = 1'b1;
                else if (m_p == 2 + m_n * L) o.done = 1'b1;
                else begin
                    off = (m_p - 2) % L;
                    it = (m_p - 2) / L;
                    if (off == 0) begin
                        o.opt_run = 1'b1;
                        o.opt_command = m_mode;
                    end else if (off <= D) begin
                        o.or_dist = (off == 1) ? D_FIRST : (off == D) ? D_LAST : D_RUN;
                        o.tw_dist = o.or_dist;
                    end else if (off == D + 1) begin
                        o.or_met = 1'b1; o.tw_met = 1'b1; o.exp_run = 1'b1;
                    end else if (off == D + 2) begin
                        o.or_rep = (it % 2 == 0);
                        o.tw_rep = (it % 2 == 1);
                    end else begin
                        o.or_ex = 1'b1; o.tw_ex = 1'b1;
                    end
                end
            end
        end
        return o;
    endfunction

    // Model advance: computes what the outputs must be in the cycle after this edge.
    always @(posedge clk) begin
        if (reset) begin
            m_running = 0; m_holding = 0; m_mode = OPT_THRU; m_recip = '0;
        end else if (m_running) begin
            if (m_holding) begin
                if (!pause) begin m_holding = 0; m_p++; end
            end else if (m_p == 2 + m_n * L) m_running = 0;
            else if (m_p >= 2 && (m_p - 2) % L == L - 1 && pause) m_holding = 1;
            else m_p++;
        end else if (start) begin
            m_running = 1; m_holding = 0; m_p = 1; m_n = run_times;
            m_mode = mode; m_recip = recip;
        end
        exp_o = model_out();
        chk_en = 1;
    end

    // Scoreboard compare, every cycle, away from the active edge.
    always @(negedge clk) begin
        outs_t got;
        int rel;
        if (chk_en) begin
            got = pack_dut();
            n_checks++;
            if (got !== exp_o) begin
                n_errors++;
                $display("FAIL outputs cyc=%0d got=%h expected=%h", cyc, got, exp_o);
            end
            rel = cyc - t0;
            if (rel >= 0 && rel < 64) trace[rel] = got;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic wait_rel(input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    task automatic pulse_start(input int n, input opt_command_t m, input logic [16:0] r);
        foreach (trace[i]) trace[i] = '0;
        t0 = cyc;
        start = 1'b1; run_times = W'(n); mode = m; recip = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cnt_opt, cnt_done;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("reset_outs", pack_dut(), '0);
        check("reset_busy", busy, 0);

        // Two iterations, OPT_TWO
        pulse_start(2, OPT_TWO, 17'h1_2345);
        wait_rel(26);
        #1;
        exp_q = {W'(2), W'(12)};
        cnt_opt = 0;
        for (int r = 1; r < 25; r++) begin
            if (trace[r].opt_run) begin
                cnt_opt++;
                if (exp_q.size() > 0) check("opt_run_cycle", W'(r), exp_q.pop_front());
            end
        end
        check("opt_run_count", cnt_opt, 2);
        check("exp_init_c1", trace[1].exp_init, 1);
        check("opt_command_c2", trace[2].opt_command, OPT_TWO);
        check("dist_c3", trace[3].or_dist, D_FIRST);
        check("dist_c4", trace[4].or_dist, D_RUN);
        check("dist_c5", trace[5].tw_dist, D_RUN);
        check("dist_c6", trace[6].tw_dist, D_LAST);
        check("or_rep_c8", {trace[8].or_rep, trace[8].tw_rep}, 2'b10);
        check("tw_rep_c18", {trace[18].or_rep, trace[18].tw_rep}, 2'b01);
        check("done_c21", trace[21].done, 0);
        check("done_c22", {trace[22].done, trace[22].busy}, 2'b11);
        check("busy_c23", trace[23].busy, 0);
        check("exp_recip", trace[5].exp_recip, 17'h1_2345);

        // Zero iterations
        pulse_start(0, OPT_OR0, 17'h0_00ff);
        wait_rel(6);
        #1;
        check("zero_init_c1", trace[1].exp_init, 1);
        check("zero_done_c2", trace[2].done, 1);
        check("zero_busy_c3", trace[3].busy, 0);
        cnt_opt = 0;
        for (int r = 1; r < 6; r++) cnt_opt += int'(trace[r].opt_run) + int'(trace[r].or_ex);
        check("zero_no_strobes", cnt_opt, 0);

        // Second start while busy is dropped
        pulse_start(2, OPT_OR1, 17'(($urandom)));
        wait_rel(5);
        start = 1'b1; run_times = W'(7);
        @(negedge clk);
        start = 1'b0;
        wait_rel(26);
        #1;
        check("restart_done_c22", trace[22].done, 1);
        check("restart_busy_c23", trace[23].busy, 0);
        check("restart_opt_com", trace[23].opt_com, OPT_OR1);

        // Reset mid-run
        pulse_start(3, OPT_TWO, 17'h0_1111);
        wait_rel(7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_outs_c8", pack_dut(), '0);
        wait_rel(40);
        cnt_done = 0;
        for (int r = 8; r < 40; r++) cnt_done += int'(trace[r].done);
        check("midreset_no_done", cnt_done, 0);
        pulse_start(3, OPT_OR0, 17'h1_ffff);
        wait_rel(34);
        #1;
        check("after_reset_done_c32", {trace[31].done, trace[32].done}, 2'b01);

`ifdef REPLICA_SEQ_PAUSE_EN
        // Pause across the end of iteration 1: HOLD in cycles 12..15
        pulse_start(2, OPT_TWO, 17'h0_0abc);
        wait_rel(11);
        pause = 1'b1;
        wait_rel(15);
        pause = 1'b0;
        wait_rel(28);
        #1;
        for (int r = 12; r < 16; r++) begin
            check("hold_busy", trace[r].busy, 1);
            check("hold_silent", {trace[r].opt_run, trace[r].or_ex, trace[r].or_dist, trace[r].done}, 0);
        end
        check("pause_opt_c16", trace[16].opt_run, 1);
        check("pause_done_c26", {trace[25].done, trace[26].done}, 2'b01);
`endif

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 11) == 0);
            run_times = W'($urandom_range(0, 3));
            mode = opt_command_t'($urandom_range(0, 3));
            recip = 17'($urandom);
            reset = ($urandom_range(0, 299) == 0);
`ifdef REPLICA_SEQ_PAUSE_EN
            pause = ($urandom_range(0, 2) == 0);
`endif
        end
        @(negedge clk);
        start = 1'b0; reset = 1'b0; pause = 1'b0;
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
